fb_pingpong_ctrl: RTL and testbench



---
 rtl/fb_pkg.sv | 24 ++
 rtl/sat_counter.sv | 27 ++
 rtl/fb_pingpong_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fb_pingpong_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : fb_pkg                                                |
// | Purpose  : Shared types and defaults for the ping-pong frame     |
// |            buffer (write sequencer and display read side).       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package fb_pkg;

  // Write-side sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } fb_state_e;

  // Default geometry: 198x198 RGB332 frame per bank
  localparam int FB_FRAME_PIXELS = 39204;
  localparam int FB_ADDR_W       = 16;
  localparam int FB_DATA_W       = 8;
  localparam int FB_DROP_W       = 16;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : sat_counter                                           |
// | Purpose  : Up-counter that sticks at all-ones; cleared only by   |
// |            the asynchronous reset.                               |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment on request unless already saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/fb_pingpong_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : fb_pingpong_ctrl                                      |
// | Purpose  : Writes complete sobel frames into one half of a       |
// |            2-bank BRAM and swaps banks with the display only at  |
// |            a display frame boundary.                             |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module fb_pingpong_ctrl
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int DROP_W       = FB_DROP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pi_flag,
  input  logic              pi_sof,
  input  logic [DATA_W-1:0] pi_rgb,
  input  logic              disp_frame_end,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_bank,
  output logic              frame_ready,
  output logic              swap_pulse,
  output logic              sync_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  // Reject geometries the index counter cannot represent
  generate
    if ((FRAME_PIXELS < 4) || (FRAME_PIXELS > (2 ** ADDR_W))) begin : g_bad_geometry
      $error("fb_pingpong_ctrl: FRAME_PIXELS out of range for ADDR_W");
    end
  endgenerate

  fb_state_e         state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              rd_bank_nxt;
  logic              frame_ready_nxt;
  logic              swap_nxt;
  logic              sync_err_nxt;
  logic              do_write;
  logic [ADDR_W-1:0] write_idx;
  logic              drop_inc;

  // Next-state, index and bank bookkeeping; the write port is loaded from do_write/write_idx
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    wr_bank_nxt     = wr_bank;
    rd_bank_nxt     = rd_bank;
    frame_ready_nxt = frame_ready;
    swap_nxt        = 1'b0;
    sync_err_nxt    = sync_err;
    do_write        = 1'b0;
    write_idx       = idx;
    drop_inc        = 1'b0;

    case (state)
      IDLE: begin
        // Only a start-of-frame pixel opens a new frame; stray pixels are ignored
        if (pi_flag && pi_sof) begin
          do_write  = 1'b1;
          write_idx = '0;
          idx_nxt   = ONE_IDX;
          state_nxt = FILL;
        end
      end

      FILL: begin
        if (pi_flag) begin
          do_write = 1'b1;
          if (pi_sof) begin
            // Unexpected frame start: restart the frame in place
            write_idx    = '0;
            idx_nxt      = ONE_IDX;
            sync_err_nxt = 1'b1;
          end else if (idx == LAST_IDX) begin
            // A swap request in this same cycle is deliberately not honoured
            idx_nxt         = '0;
            state_nxt       = FULL;
            frame_ready_nxt = 1'b1;
          end else begin
            idx_nxt = idx + ONE_IDX;
          end
        end
      end

      FULL: begin
        // Bank is frozen until the display takes it; incoming pixels are lost
        drop_inc = pi_flag;
        if (disp_frame_end) begin
          rd_bank_nxt     = wr_bank;
          wr_bank_nxt     = ~wr_bank;
          frame_ready_nxt = 1'b0;
          swap_nxt        = 1'b1;
          state_nxt       = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Sequencer state, bank pointers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      swap_pulse  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      frame_ready <= frame_ready_nxt;
      swap_pulse  <= swap_nxt;
      sync_err    <= sync_err_nxt;
    end
  end

  // BRAM write port, one cycle behind the accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= {wr_bank, write_idx};
        wr_data <= pi_rgb;
      end
    end
  end

  sat_counter #(
    .WIDTH (DROP_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  // The display must never be reading the bank being written
  a_bank_exclusive : assert property (@(posedge clk) disable iff (!rst_n) wr_bank != rd_bank);

endmodule : fb_pingpong_ctrl
`default_nettype wire

// File: tb/tb_fb_pingpong_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_fb_pingpong_ctrl                                   |
// | Purpose  : Self-checking bench for fb_pingpong_ctrl with a       |
// |            16-pixel frame and 4-bit per-bank address.            |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_fb_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pi_flag, pi_sof, disp_frame_end;
  logic [7:0]  pi_rgb;
  logic        wr_en, rd_bank, frame_ready, swap_pulse, sync_err;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic        flag;
    logic        sof;
    logic [7:0]  rgb;
    logic        dfe;
    logic        wr;
    logic [4:0]  addr;
    logic        fr;
    logic        sw;
    logic        rb;
    logic        se;
    logic [15:0] drop;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[$];

  fb_pingpong_ctrl #(
    .FRAME_PIXELS (16),
    .ADDR_W       (4),
    .DATA_W       (8),
    .DROP_W       (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pi_flag        (pi_flag),
    .pi_sof         (pi_sof),
    .pi_rgb         (pi_rgb),
    .disp_frame_end (disp_frame_end),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_bank        (rd_bank),
    .frame_ready    (frame_ready),
    .swap_pulse     (swap_pulse),
    .sync_err       (sync_err),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard side: every write the DUT performs must match the oldest expected one
  always @(posedge clk) begin : monitor
    wr_t e;
    #1;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
  end

  // One clock of stimulus; returns 2 time units after the capturing edge
  task automatic drive(input logic f, input logic s, input logic [7:0] d, input logic dfe);
    @(negedge clk);
    pi_flag = f; pi_sof = s; pi_rgb = d; disp_frame_end = dfe;
    @(posedge clk);
    #2;
    chk("missing_write", exp_q.size(), 0);
  endtask

  task automatic pix(input logic s, input logic [7:0] d, input logic [4:0] a);
    exp_q.push_back('{addr: a, data: d});
    drive(1'b1, s, d, 1'b0);
  endtask

  function automatic vec_t mk(input logic f, input logic s, input logic [7:0] d, input logic dfe,
                              input logic wr, input logic [4:0] a, input logic fr, input logic sw,
                              input logic rb, input logic se, input logic [15:0] drop);
    vec_t v;
    v = '{flag: f, sof: s, rgb: d, dfe: dfe, wr: wr, addr: a, fr: fr, sw: sw, rb: rb, se: se, drop: drop};
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},       {31'd0, wr_en},       0);
    chk({tag, "_wr_addr"},     {27'd0, wr_addr},     0);
    chk({tag, "_wr_data"},     {24'd0, wr_data},     0);
    chk({tag, "_rd_bank"},     {31'd0, rd_bank},     1);
    chk({tag, "_frame_ready"}, {31'd0, frame_ready}, 0);
    chk({tag, "_swap_pulse"},  {31'd0, swap_pulse},  0);
    chk({tag, "_sync_err"},    {31'd0, sync_err},    0);
    chk({tag, "_drop_cnt"},    {16'd0, drop_cnt},    0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    vec_t v;

    // Frame A into bank 0, then swap
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1, i == 0, 8'(i), 0, 1, 5'(i), i == 15, 0, 1, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    // Pixel without sof in IDLE is neither written nor counted
    vt.push_back(mk(1, 0, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0));
    // Frame B into bank 1
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1, i == 0, 8'hA0 + 8'(i), 0, 1, 5'h10 + 5'(i), i == 15, 0, 0, 0, 0));
    // Five drops while FULL, then a sixth coinciding with the swap
    for (int k = 0; k < 5; k++)
      vt.push_back(mk(1, 0, 8'hE0 + 8'(k), 0, 0, 0, 1, 0, 0, 0, 16'(k + 1)));
    vt.push_back(mk(1, 0, 8'hEE, 1, 0, 0, 0, 1, 1, 0, 6));
    vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 6));

    rst_n = 1'b0; pi_flag = 1'b0; pi_sof = 1'b0; pi_rgb = 8'h00; disp_frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      if (v.wr) exp_q.push_back('{addr: v.addr, data: v.rgb});
      drive(v.flag, v.sof, v.rgb, v.dfe);
      chk("vec_wr_en",       {31'd0, wr_en},       {31'd0, v.wr});
      chk("vec_frame_ready", {31'd0, frame_ready}, {31'd0, v.fr});
      chk("vec_swap_pulse",  {31'd0, swap_pulse},  {31'd0, v.sw});
      chk("vec_rd_bank",     {31'd0, rd_bank},     {31'd0, v.rb});
      chk("vec_sync_err",    {31'd0, sync_err},    {31'd0, v.se});
      chk("vec_drop_cnt",    {16'd0, drop_cnt},    {16'd0, v.drop});
    end

    // Resync: sof arriving at index 7 restarts the frame in bank 0
    pix(1'b1, 8'h30, 5'h00);
    for (int k = 1; k < 7; k++) pix(1'b0, 8'h30 + 8'(k), 5'(k));
    pix(1'b1, 8'h40, 5'h00);
    chk("resync_sync_err", {31'd0, sync_err}, 1);
    for (int k = 1; k < 16; k++) begin
      pix(1'b0, 8'h40 + 8'(k), 5'(k));
      chk("resync_frame_ready", {31'd0, frame_ready}, {31'd0, k == 15});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("resync_swap",        {31'd0, swap_pulse}, 1);
    chk("resync_rd_bank",     {31'd0, rd_bank},    0);
    chk("sticky_after_swap",  {31'd0, sync_err},   1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("swap_one_cycle",     {31'd0, swap_pulse}, 0);

    // Asynchronous reset mid-FILL at index 4 in bank 1
    pix(1'b1, 8'h50, 5'h10);
    for (int k = 1; k < 4; k++) pix(1'b0, 8'h50 + 8'(k), 5'h10 + 5'(k));
    chk("pre_reset_wr_en", {31'd0, wr_en}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h77, 1'b0);
    chk("post_reset_ignored_wr", {31'd0, wr_en},    0);
    drive(1'b1, 1'b0, 8'h78, 1'b0);
    chk("post_reset_ignored_drop", {16'd0, drop_cnt}, 0);

    // Display frame end during FILL at index 9 is ignored
    pix(1'b1, 8'h60, 5'h00);
    for (int k = 1; k < 9; k++) pix(1'b0, 8'h60 + 8'(k), 5'(k));
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fill_dfe_swap",    {31'd0, swap_pulse},  0);
    chk("fill_dfe_rd_bank", {31'd0, rd_bank},     1);
    chk("fill_dfe_ready",   {31'd0, frame_ready}, 0);
    pix(1'b0, 8'h69, 5'h09);
    chk("fill_continue_wr", {31'd0, wr_en}, 1);

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fb_pingpong_ctrl
`default_nettype wire
